// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO; occupancy held in its own counter so
// full and empty stay distinct when the wrapping pointers meet.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: clearing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_8n1.sv
// UART transmitter: valid/ready byte input into a small FIFO, serialised as
// start / 8 data bits LSB first / STOP_BITS stop bits on an idle-high line.
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 140,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          tx_en,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    import uart_pkg::*;

    localparam int BW = $clog2(CLKS_PER_BIT);

    uart_state_e               state;
    logic [BW-1:0]             baud_cnt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] head;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;
    logic                      baud_last;
    logic                      stop_last;

    // in_ready depends only on registered FIFO occupancy, never on pop.
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign stop_last = (bit_cnt == 3'(STOP_BITS - 1));
    assign pop       = tx_en && !empty &&
                       ((state == IDLE) || (state == STOP && baud_last && stop_last));
    assign busy      = (state != IDLE) || !empty;

    uart_tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // tx carries an async set so reset forces the line idle mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= head;
                        tx       <= 1'b0;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                            tx      <= 1'b1;
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (stop_last) begin
                            bit_cnt <= '0;
                            // Chaining straight into the next start bit leaves no idle gap.
                            if (pop) begin
                                shift <= head;
                                tx    <= 1'b0;
                                state <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1: expected line levels come from frame arithmetic and
// a sampling receiver, against three parameterisations of the transmitter.
module tb_uart_tx_8n1;

    localparam int CPB = 4;
    localparam int CPB_SLOW = 140;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]    in_data_a, in_data_b, in_data_c;
    logic          in_valid_a, in_valid_b, in_valid_c;
    logic          in_ready_a, in_ready_b, in_ready_c;
    logic          tx_en_a, tx_en_b, tx_en_c;
    logic          tx_a, tx_b, tx_c;
    logic          busy_a, busy_b, busy_c;
    logic [CW-1:0] fifo_count_a, fifo_count_b, fifo_count_c;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];
    logic wave [0:511];

    uart_tx_8n1 #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .tx_en(tx_en_a), .tx(tx_a), .busy(busy_a),
        .fifo_count(fifo_count_a));

    uart_tx_8n1 #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .tx_en(tx_en_b), .tx(tx_b), .busy(busy_b),
        .fifo_count(fifo_count_b));

    uart_tx_8n1 #(.CLKS_PER_BIT(CPB_SLOW), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(in_valid_c),
        .in_ready(in_ready_c), .tx_en(tx_en_c), .tx(tx_c), .busy(busy_c),
        .fifo_count(fifo_count_c));

    // Line level k cycles after the falling edge of a frame carrying b.
    function automatic logic frame_level(logic [7:0] b, int k, int cpb);
        if (k < cpb) return 1'b0;
        if (k < 9 * cpb) return b[(k - cpb) / cpb];
        return 1'b1;
    endfunction

    function automatic logic line(int sel);
        case (sel)
            0: return tx_a;
            1: return tx_b;
            default: return tx_c;
        endcase
    endfunction

    // Behavioural receiver: find the start edge, sample mid-bit.
    task automatic rx_byte(input int sel, input int cpb, output logic [7:0] b, output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        b = 8'h00;
        while (line(sel) !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            ok = 1'b0;
            return;
        end
        repeat (cpb / 2) @(negedge clk);
        if (line(sel) !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(negedge clk);
            b[i] = line(sel);
        end
        repeat (cpb) @(negedge clk);
        if (line(sel) !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (tx_a !== 1'b1 || tx_b !== 1'b1 || tx_c !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_tx: got %b%b%b expected 111", tx_a, tx_b, tx_c);
        end
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", busy_a);
        end
        vectors++;
        if (in_ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready_a);
        end
        vectors++;
        if (fifo_count_a !== '0) begin
            miscompares++;
            $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count_a);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_55;
        @(negedge clk);
        in_data_a = 8'h55;
        in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        vectors++;
        if (tx_a !== 1'b1 || busy_a !== 1'b1 || fifo_count_a !== CW'(1)) begin
            miscompares++;
            $display("FAIL single_accept: tx=%b busy=%b count=%0d expected 1 1 1", tx_a, busy_a, fifo_count_a);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            vectors++;
            if (tx_a !== frame_level(8'h55, k, CPB) || busy_a !== 1'b1) begin
                miscompares++;
                $display("FAIL single_wave[%0d]: tx=%b busy=%b expected tx=%b busy=1", k, tx_a, busy_a, frame_level(8'h55, k, CPB));
            end
        end
        @(negedge clk);
        vectors++;
        if (busy_a !== 1'b0 || tx_a !== 1'b1) begin
            miscompares++;
            $display("FAIL single_end: busy=%b tx=%b expected 0 1", busy_a, tx_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [2];
        logic [7:0] dec;
        bytes[0] = 8'hA5;
        bytes[1] = 8'h3C;
        @(negedge clk);
        in_data_a = bytes[0];
        in_valid_a = 1'b1;
        @(negedge clk);
        in_data_a = bytes[1];
        @(negedge clk);
        in_valid_a = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge clk);
            wave[k] = tx_a;
            vectors++;
            if (tx_a !== frame_level(bytes[k / 40], k % 40, CPB) || busy_a !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_wave[%0d]: tx=%b busy=%b expected tx=%b busy=1", k, tx_a, busy_a, frame_level(bytes[k / 40], k % 40, CPB));
            end
        end
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) dec[i] = wave[f * 40 + CPB + CPB * i + CPB / 2];
            vectors++;
            if (dec !== bytes[f]) begin
                miscompares++;
                $display("FAIL b2b_decode[%0d]: got %02h expected %02h", f, dec, bytes[f]);
            end
        end
        @(negedge clk);
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end_busy: got %b expected 0", busy_a);
        end
    endtask

    task automatic test_fifo_full;
        logic [7:0] b [6];
        int idx, first_low, acc_at_low, rehigh;
        logic [CW-1:0] cnt_at_low;
        bit pend;
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom_range(0, 255));
        idx = 0;
        pend = 1'b0;
        first_low = -1;
        acc_at_low = -1;
        rehigh = -1;
        cnt_at_low = '0;
        for (int t = 0; t <= 242; t++) begin
            @(negedge clk);
            wave[t] = tx_a;
            if (in_valid_a && pend) idx++;
            if (idx < 6) begin
                in_valid_a = 1'b1;
                in_data_a = b[idx];
            end else begin
                in_valid_a = 1'b0;
            end
            pend = in_ready_a;
            if (!in_ready_a && first_low < 0) begin
                first_low = t;
                acc_at_low = idx;
                cnt_at_low = fifo_count_a;
            end
            if (in_ready_a && first_low >= 0 && rehigh < 0) rehigh = t;
        end
        vectors++;
        if (acc_at_low !== 5 || cnt_at_low !== CW'(4)) begin
            miscompares++;
            $display("FAIL full_accepted: accepted=%0d count=%0d expected 5 4", acc_at_low, cnt_at_low);
        end
        vectors++;
        if (rehigh !== 42) begin
            miscompares++;
            $display("FAIL full_reready_cycle: got %0d expected 42", rehigh);
        end
        for (int t = 2; t < 242; t++) begin
            vectors++;
            if (wave[t] !== frame_level(b[(t - 2) / 40], (t - 2) % 40, CPB)) begin
                miscompares++;
                $display("FAIL full_wave[%0d]: got %b expected %b", t, wave[t], frame_level(b[(t - 2) / 40], (t - 2) % 40, CPB));
            end
        end
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL full_end_busy: got %b expected 0", busy_a);
        end
    endtask

    task automatic test_reset_midframe;
        @(negedge clk);
        in_data_a = 8'hFF;
        in_valid_a = 1'b1;
        @(negedge clk);
        in_data_a = 8'($urandom_range(0, 255));
        @(negedge clk);
        in_data_a = 8'($urandom_range(0, 255));
        @(negedge clk);
        in_valid_a = 1'b0;
        repeat (12) @(negedge clk);
        vectors++;
        if (fifo_count_a !== CW'(2) || busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_before: count=%0d busy=%b expected 2 1", fifo_count_a, busy_a);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (tx_a !== 1'b1 || fifo_count_a !== '0 || busy_a !== 1'b0 || in_ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_async: tx=%b count=%0d busy=%b ready=%b expected 1 0 0 1", tx_a, fifo_count_a, busy_a, in_ready_a);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            vectors++;
            if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_quiet[%0d]: tx=%b busy=%b expected 1 0", k, tx_a, busy_a);
            end
        end
        // Reset during a start bit must lift the line without waiting for a clock.
        in_data_a = 8'($urandom_range(0, 255));
        in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        @(negedge clk);
        vectors++;
        if (tx_a !== 1'b0) begin
            miscompares++;
            $display("FAIL rststart_low: got %b expected 0", tx_a);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (tx_a !== 1'b1) begin
            miscompares++;
            $display("FAIL rststart_async_tx: got %b expected 1", tx_a);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tx_en_hold;
        logic [7:0] b [2];
        b[0] = 8'($urandom_range(0, 255));
        b[1] = 8'($urandom_range(0, 255));
        tx_en_a = 1'b0;
        @(negedge clk);
        in_data_a = b[0];
        in_valid_a = 1'b1;
        @(negedge clk);
        in_data_a = b[1];
        @(negedge clk);
        in_valid_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if (tx_a !== 1'b1 || fifo_count_a !== CW'(2) || busy_a !== 1'b1) begin
                miscompares++;
                $display("FAIL hold[%0d]: tx=%b count=%0d busy=%b expected 1 2 1", k, tx_a, fifo_count_a, busy_a);
            end
        end
        tx_en_a = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            vectors++;
            if (tx_a !== frame_level(b[k / 40], k % 40, CPB)) begin
                miscompares++;
                $display("FAIL hold_release_wave[%0d]: got %b expected %b", k, tx_a, frame_level(b[k / 40], k % 40, CPB));
            end
        end
        @(negedge clk);
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_end_busy: got %b expected 0", busy_a);
        end
    endtask

    task automatic test_tx_en_midframe;
        logic [7:0] b [2];
        b[0] = 8'($urandom_range(0, 255));
        b[1] = 8'($urandom_range(0, 255));
        @(negedge clk);
        in_data_a = b[0];
        in_valid_a = 1'b1;
        @(negedge clk);
        in_data_a = b[1];
        @(negedge clk);
        in_valid_a = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 10) tx_en_a = 1'b0;
            vectors++;
            if (tx_a !== frame_level(b[0], k, CPB)) begin
                miscompares++;
                $display("FAIL midoff_wave[%0d]: got %b expected %b", k, tx_a, frame_level(b[0], k, CPB));
            end
        end
        vectors++;
        if (fifo_count_a !== CW'(1) || busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL midoff_held: count=%0d busy=%b expected 1 1", fifo_count_a, busy_a);
        end
        tx_en_a = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            vectors++;
            if (tx_a !== frame_level(b[1], k, CPB)) begin
                miscompares++;
                $display("FAIL midoff_resume[%0d]: got %b expected %b", k, tx_a, frame_level(b[1], k, CPB));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stop2;
        logic [7:0] b [2];
        b[0] = 8'h00;
        b[1] = 8'($urandom_range(0, 255));
        @(negedge clk);
        in_data_b = b[0];
        in_valid_b = 1'b1;
        @(negedge clk);
        in_data_b = b[1];
        @(negedge clk);
        in_valid_b = 1'b0;
        for (int k = 0; k < 88; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (tx_b !== frame_level(b[k / 44], k % 44, CPB)) begin
                miscompares++;
                $display("FAIL stop2_wave[%0d]: got %b expected %b", k, tx_b, frame_level(b[k / 44], k % 44, CPB));
            end
        end
        @(negedge clk);
        vectors++;
        if (busy_b !== 1'b0 || tx_b !== 1'b1) begin
            miscompares++;
            $display("FAIL stop2_end: busy=%b tx=%b expected 0 1", busy_b, tx_b);
        end
    endtask

    task automatic test_random;
        fork
            begin : driver
                int n;
                bit acc;
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 60)) @(negedge clk);
                    in_data_a = 8'($urandom_range(0, 255));
                    in_valid_a = 1'b1;
                    n = 0;
                    do begin
                        acc = in_ready_a;
                        @(negedge clk);
                        n++;
                    end while (!acc && n < 2000);
                    in_valid_a = 1'b0;
                    if (acc) exp_q.push_back(in_data_a);
                    vectors++;
                    if (!acc) begin
                        miscompares++;
                        $display("FAIL rand_accept[%0d]: ready=0 expected 1 within 2000 cycles", i);
                    end
                end
            end
            begin : receiver
                logic [7:0] got;
                logic [7:0] want;
                bit ok;
                for (int i = 0; i < 10; i++) begin
                    rx_byte(0, CPB, got, ok);
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    vectors++;
                    if (!ok || got !== want) begin
                        miscompares++;
                        $display("FAIL rand_rx[%0d]: got %02h framing_ok=%0d expected %02h", i, got, ok, want);
                    end
                end
            end
        join
        repeat (8) @(negedge clk);
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_end_busy: got %b expected 0", busy_a);
        end
    endtask

    task automatic test_slow_receiver;
        logic [7:0] got;
        logic [7:0] want;
        bit ok;
        @(negedge clk);
        in_data_c = 8'h48;
        in_valid_c = 1'b1;
        exp_q.push_back(8'h48);
        @(negedge clk);
        in_data_c = 8'h69;
        exp_q.push_back(8'h69);
        @(negedge clk);
        in_valid_c = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rx_byte(2, CPB_SLOW, got, ok);
            want = exp_q.pop_front();
            vectors++;
            if (!ok || got !== want) begin
                miscompares++;
                $display("FAIL slow_rx[%0d]: got %02h framing_ok=%0d expected %02h", i, got, ok, want);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_data_a = '0;  in_data_b = '0;  in_data_c = '0;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
        tx_en_a = 1'b1;  tx_en_b = 1'b1;  tx_en_c = 1'b1;
        test_reset();
        test_single_55();
        test_back_to_back();
        test_fifo_full();
        test_reset_midframe();
        test_tx_en_hold();
        test_tx_en_midframe();
        test_stop2();
        test_random();
        test_slow_receiver();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_8n1.md
Name: uart_tx_8n1

Overview:
- Synthesizable UART transmitter driving the e203 SoC uart_rx pin, for the sim harness and the FPGA host-to-core link.
- It is the transmit end of the 8N1 serial link whose receive side is sampled from gpio[17].
- Bytes are accepted on a valid/ready interface into a small FIFO and serialised as start / 8 data (LSB first) / stop.
- Line idles high.

Parameters:
- CLKS_PER_BIT, 140, clock cycles per bit. 16 MHz clock with 8.75 us bit time. Legal values are 2 or more.
- FIFO_DEPTH, 4, byte FIFO entries. Must be a power of 2, 2 or more.
- STOP_BITS, 1, number of stop bits. Legal values are 1 or 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_data  in  8  byte to send
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept a byte
- tx_en  in  1  allow new frames to start
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress or FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes held in FIFO

Behaviour:
- Reset (async, rst=1):
  - tx=1, busy=0, in_ready=1, fifo_count=0.
  - FSM goes to IDLE. FIFO pointers, baud counter and bit counter are cleared.
  - tx is a flop with async set, so the line returns high immediately, even mid-frame. The partial frame is abandoned and the FIFO contents are discarded.
- Handshake:
  - A byte is written on a rising edge where in_valid && in_ready.
  - in_ready = !full. It is derived from registered FIFO state only, with no combinational path from the FSM pop.
  - in_valid while in_ready=0 is ignored. The source must hold in_data/in_valid until accepted.
- FIFO:
  - First-word-fall-through.
  - Simultaneous push and pop when not full and not empty keeps count unchanged. Push to an empty FIFO plus pop in the same cycle cannot occur, because a pop requires non-empty at the prior edge.
  - Pointers wrap modulo FIFO_DEPTH. The count is held separately to distinguish full from empty.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If tx_en && !empty at an edge: pop the head, load the shift register, set tx=0, go to START, baud_cnt=0.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then tx=shift[0], bit_cnt=0, go to DATA.
  - DATA: each bit lasts CLKS_PER_BIT cycles. At the end of a bit, shift right and increment bit_cnt. After bit 7, set tx=1 and go to STOP.
  - STOP: hold tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end:
    - if tx_en && !empty, pop, set tx=0 and go to START, giving zero idle gap between frames;
    - otherwise go to IDLE.
- Latency: a byte accepted at edge E into an empty FIFO with the FSM in IDLE gives a tx falling edge registered at E+1.
- Frame length is (9+STOP_BITS)*CLKS_PER_BIT cycles from the tx falling edge to the next possible start.
- tx_en deasserted mid-frame: the current frame completes, then the FSM holds IDLE. The FIFO still accepts bytes.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - It counts 0..CLKS_PER_BIT-1 and the bit ends at the terminal count. It never wraps mid-bit.
- busy = (state != IDLE) || !empty. It is registered, or combinational from registered state.
- tx is always a registered output (glitch-free).

Decomposition:
- Package uart_pkg:
  - typedef for the FSM state enum (IDLE/START/DATA/STOP);
  - localparam UART_DATA_BITS=8.
- One sub-module: uart_tx_fifo, parameterised by width and depth. Ports: push/pop/din/dout/full/empty/count.
- The FSM, baud counter and shifter live in uart_tx_8n1.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Single byte 0x55 with tx_en=1:
  - tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
  - Total 40 cycles. busy drops the cycle after STOP ends.
- Back-to-back 0xA5 then 0x3C pushed on consecutive edges: both frames 40 cycles each with no idle cycle between them. Bits decoded LSB-first equal 0xA5 and 0x3C.
- Six bytes pushed continuously with FIFO_DEPTH=4:
  - in_ready deasserts after the FIFO reaches 4 held bytes. One byte was already popped into the shifter, so 5 bytes are accepted.
  - in_ready reasserts on the edge after the next pop.
  - All 6 bytes transmitted in order.
- rst pulsed mid-DATA of byte 0xFF with 2 bytes queued: tx=1 immediately (before the next clk edge), fifo_count=0, busy=0. After release, no frame is sent until a new push.
- tx_en=0 with 2 bytes pushed: tx stays 1, fifo_count=2, busy=1. Raising tx_en starts the first frame 1 cycle later.
- STOP_BITS=2, byte 0x00: tx low 36 cycles, then high 8 cycles before the next start.
- Bench check: a behavioural 8N1 receiver at CLKS_PER_BIT=140 decodes 0x48,0x69 correctly.
